// File: rtl/rom_stream_reader_pkg.sv
// rom_stream_reader_pkg: states and default widths
// shared by the ROM stream reader and its ROM.
package rom_stream_reader_pkg;

  localparam int DEF_BLOCK_LENGTH = 8;
  localparam int DEF_MEM_DEPTH    = 400;
  localparam int DEF_ADDR_W       = 9;
  localparam int FIFO_DEPTH       = 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

  function automatic logic is_busy(input state_e s);
    return (s == S_RUN) || (s == S_DRAIN);
  endfunction

endpackage

// File: rtl/rom_stream_skid_fifo.sv
// rom_stream_skid_fifo: 2-entry FIFO that absorbs
// words already in flight when downstream stalls.
module rom_stream_skid_fifo
  import rom_stream_reader_pkg::*;
#(
  parameter int WIDTH = DEF_BLOCK_LENGTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [1:0]       count
);

  logic [1:0][WIDTH-1:0] mem_q, mem_d;
  logic                  wr_q, wr_d;
  logic                  rd_q, rd_d;
  logic [1:0]            count_q, count_d;
  logic                  push_ok, pop_ok;

  // A pop frees the head slot, so a push may land in it the same cycle
  always_comb begin
    pop_ok  = pop && (count_q != 2'd0);
    push_ok = push &&
              ((count_q != 2'(FIFO_DEPTH)) || pop_ok);
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    if (push_ok) begin
      mem_d[wr_q] = push_data;
      wr_d        = ~wr_q;
    end
    if (pop_ok) begin
      rd_d = ~rd_q;
    end
    count_d = count_q + {1'b0, push_ok}
                      - {1'b0, pop_ok};
  end

  // Storage and pointer registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_q   <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      count_q <= 2'd0;
    end else begin
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  assign head  = mem_q[rd_q];
  assign count = count_q;

endmodule

// File: rtl/rom_stream_reader.sv
// rom_stream_reader: walks a ROM address range and streams words.
// ROM_STREAM_LOOP_EN adds loop/stop ports for cyclic reads.
module rom_stream_reader
  import rom_stream_reader_pkg::*;
#(
  parameter int BLOCK_LENGTH = DEF_BLOCK_LENGTH,
  parameter int MEM_DEPTH    = DEF_MEM_DEPTH,
  parameter int ADDR_W       = DEF_ADDR_W
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       startAddress,
  input  logic [ADDR_W:0]         length,
`ifdef ROM_STREAM_LOOP_EN
  input  logic                    loop,
  input  logic                    stop,
`endif
  output logic                    busy,
  output logic                    done,
  output logic [ADDR_W-1:0]       romAddress,
  output logic                    romEnable,
  input  logic [BLOCK_LENGTH-1:0] romData,
  output logic [BLOCK_LENGTH-1:0] outData,
  output logic                    outValid,
  input  logic                    outReady
);

  localparam logic [ADDR_W:0] REM_ONE =
    (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ADDR_LAST =
    ADDR_W'(MEM_DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, addr_inc;
  logic [ADDR_W:0]   rem_q, rem_d;
  logic              in_flight_q, in_flight_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [1:0]        fifo_count;
  logic              pop, room, drain_ok;
  logic              stop_now, loop_now;
`ifdef ROM_STREAM_LOOP_EN
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic              loop_q, loop_d;
`endif

  rom_stream_skid_fifo #(
    .WIDTH(BLOCK_LENGTH)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (in_flight_q),
    .push_data(romData),
    .pop      (pop),
    .head     (outData),
    .count    (fifo_count)
  );

  assign outValid = (fifo_count != 2'd0);
  assign pop      = outValid && outReady;

  // Issue only when the word it fetches is sure to have a FIFO slot
  always_comb begin
    stop_now = 1'b0;
    loop_now = 1'b0;
`ifdef ROM_STREAM_LOOP_EN
    stop_now = stop;
    loop_now = loop_q;
`endif
    room = ({1'b0, fifo_count} + {2'b00, in_flight_q})
           < (3'd2 + {2'b00, pop});
    romEnable = (state_q == S_RUN) && (rem_q != '0)
                && room && !stop_now;
    addr_inc = (addr_q == ADDR_LAST) ? '0
                                     : addr_q + 1'b1;
    drain_ok = (fifo_count == {1'b0, pop})
               && !in_flight_q;
  end

  // Sequencer next state and registered status outputs
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    in_flight_d = romEnable;
`ifdef ROM_STREAM_LOOP_EN
    base_d = base_q;
    len_d  = len_q;
    loop_d = loop_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d  = startAddress;
          rem_d   = length;
          state_d = (length == '0) ? S_DONE : S_RUN;
`ifdef ROM_STREAM_LOOP_EN
          base_d = startAddress;
          len_d  = length;
          loop_d = loop;
`endif
        end
      end
      S_RUN: begin
        if (stop_now) begin
          rem_d   = '0;
          state_d = S_DRAIN;
        end else if (romEnable) begin
          addr_d = addr_inc;
          rem_d  = rem_q - REM_ONE;
          if (rem_q == REM_ONE) begin
            if (!loop_now) begin
              state_d = S_DRAIN;
            end
`ifdef ROM_STREAM_LOOP_EN
            else begin
              addr_d = base_q;
              rem_d  = len_q;
            end
`endif
          end
        end
      end
      S_DRAIN: begin
        if (drain_ok) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = is_busy(state_d);
    done_d = (state_d == S_DONE);
  end

  // Sequencer state, address and status registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      in_flight_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef ROM_STREAM_LOOP_EN
      base_q <= '0;
      len_q  <= '0;
      loop_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      in_flight_q <= in_flight_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef ROM_STREAM_LOOP_EN
      base_q <= base_d;
      len_q  <= len_d;
      loop_q <= loop_d;
`endif
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign romAddress = addr_q;

endmodule

// File: tb/tb_rom_stream_reader.sv
// tb_rom_stream_reader: randomized scoreboard bench
// with a registered enable-gated ROM model.
module tb_rom_stream_reader;

  localparam int BL = 8;
  localparam int MD = 400;
  localparam int AW = 9;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] startAddress;
  logic [AW:0]   length;
`ifdef ROM_STREAM_LOOP_EN
  logic          loop;
  logic          stop;
`endif
  logic          busy, done;
  logic [AW-1:0] romAddress;
  logic          romEnable;
  logic [BL-1:0] romData;
  logic [BL-1:0] outData;
  logic          outValid;
  logic          outReady;

  logic [BL-1:0] mem [MD];
  logic [BL-1:0] rom_q = '0;

  int errors = 0;
  int checks = 0;
  int ready_mode = 0;
  logic [BL-1:0] exp_q [$];
  int m_base = 0, m_len = 0, m_idx = 0;
  bit m_loop = 0;
  int outstanding = 0;
  int accepted = 0;
  int mon_pop, mon_ea;
  logic [BL-1:0] mon_e;

  rom_stream_reader dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .startAddress(startAddress),
    .length      (length),
`ifdef ROM_STREAM_LOOP_EN
    .loop        (loop),
    .stop        (stop),
`endif
    .busy        (busy),
    .done        (done),
    .romAddress  (romAddress),
    .romEnable   (romEnable),
    .romData     (romData),
    .outData     (outData),
    .outValid    (outValid),
    .outReady    (outReady)
  );

  always #5 clock = ~clock;

  always_ff @(posedge clock)
    rom_q <= romEnable ? mem[romAddress] : '0;
  assign romData = rom_q;

  // downstream ready generator
  initial begin
    bit [5:0] pat;
    int pi;
    pat = 6'b101001;
    pi = 0;
    outReady = 1'b1;
    forever begin
      @(posedge clock); #1;
      case (ready_mode)
        0: outReady = 1'b1;
        1: begin
          outReady = pat[pi];
          pi = (pi + 1) % 6;
        end
        default: outReady = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // monitor: address model, occupancy bound, data scoreboard
  always @(negedge clock) begin
    if (!reset) begin
      mon_pop = (outValid && outReady) ? 1 : 0;
      if (romEnable) begin
        checks++;
        if (outstanding - mon_pop >= 2) begin
          errors++;
          $display("FAIL issue_room outstanding=%0d pop=%0d",
                   outstanding, mon_pop);
        end
        checks++;
        if (!m_loop && m_idx >= m_len) begin
          errors++;
          $display("FAIL over_issue addr=%0d idx=%0d len=%0d",
                   romAddress, m_idx, m_len);
        end else begin
          mon_ea = (m_base + (m_loop ? m_idx % m_len : m_idx))
                   % MD;
          if (int'(romAddress) != mon_ea) begin
            errors++;
            $display("FAIL rom_addr got=%0d exp=%0d",
                     romAddress, mon_ea);
          end
          exp_q.push_back(mem[mon_ea]);
        end
        m_idx++;
      end
      if (mon_pop != 0) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL out_extra got=%0h exp=none", outData);
        end else begin
          mon_e = exp_q.pop_front();
          if (outData !== mon_e) begin
            errors++;
            $display("FAIL out_data got=%0h exp=%0h",
                     outData, mon_e);
          end
        end
        accepted++;
      end
      outstanding += (romEnable ? 1 : 0) - mon_pop;
    end
  end

  task automatic check(input string nm, input int got,
                       input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  task automatic issue(input int sa, input int len,
                       input bit lp);
    m_base = sa;
    m_len = len;
    m_loop = lp;
    m_idx = 0;
    startAddress = sa[AW-1:0];
    length = len[AW:0];
`ifdef ROM_STREAM_LOOP_EN
    loop = lp;
`endif
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int c0, input int bound,
                           output int cyc);
    cyc = c0;
    while (!done && cyc < bound) begin
      @(posedge clock); #1;
      cyc++;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL done_timeout got=0 exp=1 after %0d", cyc);
    end else begin
      check("busy_at_done", int'(busy), 0);
      @(posedge clock); #1;
      check("done_width", int'(done), 0);
    end
  endtask

  task automatic run(input int sa, input int len,
                     input int mode, input bit chk_lat);
    int cyc;
    ready_mode = mode;
    issue(sa, len, 1'b0);
    wait_done(1, 400, cyc);
    if (chk_lat)
      check("latency", cyc, (len == 0) ? 1 : len + 3);
    check("queue_empty", exp_q.size(), 0);
    check("issued", m_idx, len);
  endtask

  initial begin
    int cyc;
    int tgt;
    for (int i = 0; i < MD; i++) mem[i] = BL'($urandom);
    reset = 1'b0;
    start = 1'b0;
    startAddress = '0;
    length = '0;
`ifdef ROM_STREAM_LOOP_EN
    loop = 1'b0;
    stop = 1'b0;
`endif
    #2 reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_addr", int'(romAddress), 0);
    check("rst_en", int'(romEnable), 0);
    check("rst_data", int'(outData), 0);
    check("rst_valid", int'(outValid), 0);
    reset = 1'b0;
    @(posedge clock); #1;

    run(0, 5, 0, 1'b1);
    run(398, 4, 0, 1'b1);

    // toggling ready plus a start that must be ignored while busy
    ready_mode = 1;
    issue(20, 6, 1'b0);
    startAddress = 9'd300;
    length = 10'd2;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    wait_done(2, 400, cyc);
    check("tog_queue_empty", exp_q.size(), 0);
    check("tog_issued", m_idx, 6);

    run(7, 0, 0, 1'b1);

    // reset in the middle of a 10-word read
    ready_mode = 0;
    tgt = accepted + 3;
    issue(10, 10, 1'b0);
    cyc = 0;
    while (accepted < tgt && cyc < 50) begin
      @(posedge clock); #1;
      cyc++;
    end
    check("mid_accepted", accepted, tgt);
    #2 reset = 1'b1;
    #1;
    check("mid_busy", int'(busy), 0);
    check("mid_done", int'(done), 0);
    check("mid_addr", int'(romAddress), 0);
    check("mid_en", int'(romEnable), 0);
    check("mid_data", int'(outData), 0);
    check("mid_valid", int'(outValid), 0);
    exp_q.delete();
    outstanding = 0;
    m_len = 0;
    m_idx = 0;
    m_loop = 0;
    @(posedge clock); #1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
      check("post_rst_done", int'(done), 0);
    end
    run(100, 7, 0, 1'b1);

    for (int n = 0; n < 12; n++) begin
      int md;
      md = $urandom_range(0, 2);
      run($urandom_range(0, MD - 1), $urandom_range(0, 24),
          md, md == 0);
    end
    run(399, 3, 2, 1'b0);

`ifdef ROM_STREAM_LOOP_EN
    ready_mode = 0;
    issue(0, 3, 1'b1);
    repeat (10) begin @(posedge clock); #1; end
    stop = 1'b1;
    @(posedge clock); #1;
    stop = 1'b0;
    check("loop_wrapped", int'(m_idx > 6), 1);
    wait_done(0, 40, cyc);
    check("loop_queue_empty", exp_q.size(), 0);
    repeat (4) begin
      @(posedge clock); #1;
      check("loop_done_once", int'(done), 0);
    end
    m_loop = 0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rom_stream_reader.md
# rom_stream_reader

Address sequencer and flow-control stage placed directly upstream of the registered, enable-gated ROM. On a start command it walks a contiguous address range, drives the ROM's address/enable pins, absorbs the ROM's one-cycle read latency, and presents the words as a valid/ready stream. A 2-entry skid FIFO lets downstream logic stall at any cycle without losing data in flight.

## Interface
- blockLength, 8, data word width; matches the ROM word width
- memDepth, 400, number of ROM words; addresses at or above this are never issued
- addressBitWidth, 9, ROM address width
- clock  in  1  rising-edge clock shared with the ROM
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  one-cycle command pulse; sampled only in IDLE
- startAddress  in  addressBitWidth  first address to read; must be < memDepth
- length  in  addressBitWidth+1  number of words to read; 0 to memDepth
- busy  out  1  high in RUN and DRAIN
- done  out  1  one-cycle pulse when the last word is accepted downstream
- romAddress  out  addressBitWidth  to ROM address
- romEnable  out  1  to ROM enable
- romData  in  blockLength  from ROM dataOut
- outData  out  blockLength  stream data; equals the FIFO head
- outValid  out  1  stream valid; high when the FIFO count is > 0
- outReady  in  1  stream ready from downstream

## Operation
- Reset values: busy=0, done=0, romAddress=0, romEnable=0, outData=0, outValid=0. FIFO is empty, in-flight flag is 0, state is IDLE.
- States:
  - IDLE: start=1 latches startAddress and length. If length≠0, go to RUN; if length=0, go to DONE.
  - RUN: issue reads until issued count = length, then go to DRAIN.
  - DRAIN: wait until FIFO is empty, no read is in flight, and the last word has been accepted; then go to DONE.
  - DONE: done=1 for one cycle, then return to IDLE.
- Issue rule (combinational romEnable): state=RUN, remaining>0, and (fifoCount + inFlight − pop) < 2, where pop = outValid && outReady.
- Each issue increments the address register and decrements the remaining count.
- Address wraps from memDepth−1 to 0.
- inFlight is the registered copy of romEnable. When inFlight=1, romData is written into the FIFO. romData is ignored otherwise, because the ROM outputs 0 when disabled.
- FIFO push and pop in the same cycle leave the count unchanged.
- The FIFO never overflows; this is guaranteed by the issue rule.
- start while busy is ignored.
- Reset mid-operation aborts the read, flushes the FIFO, and does not produce a done pulse.

## Timing
- start sampled at edge E0 → romEnable=1 and romAddress=startAddress during the following cycle.
- ROM registers the data at E1. The word is captured in the FIFO at E2. outValid=1 after E2, giving 2 cycles of start-to-valid latency.
- With outReady held high, throughput is one word per cycle.
- Total time from start to done is length+3 cycles.
- Backpressure: with outReady low, at most 2 words are buffered, and romEnable drops within one cycle.
- done is asserted in the cycle after the final handshake. busy falls at the same edge at which done rises.

## Configuration
- ROM_STREAM_LOOP_EN
  - Defined: the block adds an input port loop (1 bit, sampled with start). When loop=1, reaching length reloads the address from startAddress and continues reading with no bubble. An added stop input (one-cycle pulse) ends issuing; the block then goes to DRAIN and pulses done once.
  - Undefined: the loop and stop ports are absent, and each command reads exactly length words.

## Structure
- Shared package holds:
  - the state enumeration (IDLE, RUN, DRAIN, DONE)
  - the default width constants (8, 400, 9), shared with the ROM instance
- Sub-module: rom_stream_skid_fifo, a 2-entry, blockLength-wide FIFO with push/pop/count outputs, usable by other read-latency adapters.

## Test plan
- Reset then start with startAddress=0, length=5, outReady=1 → romAddress 0..4 on consecutive cycles; outData equals ROM[0..4] on 5 consecutive valid cycles; done 8 cycles after start.
- startAddress=398, length=4, memDepth=400 → addresses 398, 399, 0, 1 are issued; output order matches.
- length=6 with outReady toggling 1,0,0,1,0,1... → no lost or duplicated words; romEnable is never high while count+inFlight=2 with no pop.
- length=0 → no romEnable; done pulses 1 cycle after start; busy stays 0 in that cycle.
- Assert reset in the middle of a length=10 read after 3 words → all outputs return to their reset values immediately; no done pulse; a new start runs cleanly.
- With ROM_STREAM_LOOP_EN defined: loop=1, length=3 → addresses cycle 0,1,2,0,1,2...; stop pulse → in-flight words drain, then one done pulse.
